// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

  typedef struct packed {
    logic       valid;
    logic       tipo;
    logic [3:0] tecla;
  } entry_t;

  localparam logic [3:0] BLANK_TECLA = 4'hF;
  localparam logic       BLANK_TIPO  = 1'b0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_scan_timer.sv
// Slot sequencer: GUARD cycles blank, then DWELL cycles lit, per digit, round-robin.
// Anodes are registered from the next-state values so they line up with the current state.
module display_scan_timer
  import display_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [$clog2(NDIG)-1:0] digit_idx,
  output logic                    load,
  output logic [NDIG-1:0]         an
);

  localparam int CMAX = (GUARD > DWELL) ? GUARD : DWELL;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NDIG);

  scan_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = digit_idx;
    case (state)
      ST_BLANK: begin
        if (cnt == CW'(GUARD - 1)) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (cnt == CW'(DWELL - 1)) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = (digit_idx == IW'(NDIG - 1)) ? '0 : digit_idx + 1'b1;
        end
      end
    endcase
  end

  // First cycle of a blank interval: the top samples the buffer for this slot.
  assign load = (state == ST_BLANK) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BLANK;
      cnt       <= '0;
      digit_idx <= '0;
      an        <= '1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_idx <= idx_nxt;
      an        <= (state_nxt == ST_SHOW) ? ~(NDIG'(1) << idx_nxt) : '1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Key-code shift buffer plus digit scanner feeding the shared segment converter.
// Optional leading-zero blanking is compiled in with LZ_SUPPRESS_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [3:0]              key_tecla,
  input  logic                    key_tipo,
  output logic [3:0]              tecla_o,
  output logic                    tipo_o,
  output logic [NDIG-1:0]         an,
  output logic [$clog2(NDIG)-1:0] digit_idx,
  output logic                    ovf
);

  entry_t buf_q [NDIG];
  entry_t sel;
  logic   load;
  logic   suppress;

  display_scan_timer #(
    .NDIG  (NDIG),
    .DWELL (DWELL),
    .GUARD (GUARD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .digit_idx (digit_idx),
    .load      (load),
    .an        (an)
  );

  assign key_ready = !clr && !rst;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NDIG; i++) buf_q[i] <= '0;
      ovf <= 1'b0;
    end else if (key_valid) begin
      buf_q[0] <= {1'b1, key_tipo, key_tecla};
      for (int i = 1; i < NDIG; i++) buf_q[i] <= buf_q[i-1];
      if (buf_q[NDIG-1].valid) ovf <= 1'b1;
    end
  end

  assign sel = buf_q[digit_idx];

`ifdef LZ_SUPPRESS_EN
  // lead[i]: every entry above i is empty or a numeric zero.
  logic [NDIG-1:0] lead;
  logic            above_ok;

  always_comb begin
    above_ok = 1'b1;
    lead     = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lead[i]  = above_ok;
      above_ok = above_ok && (!buf_q[i].valid || (buf_q[i].tipo && buf_q[i].tecla == 4'h0));
    end
  end

  assign suppress = (digit_idx != '0) && lead[digit_idx] && sel.valid &&
                    sel.tipo && (sel.tecla == 4'h0);
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tecla_o <= BLANK_TECLA;
      tipo_o  <= BLANK_TIPO;
    end else if (load) begin
      if (!sel.valid || suppress) begin
        tecla_o <= BLANK_TECLA;
        tipo_o  <= BLANK_TIPO;
      end else begin
        tecla_o <= sel.tecla;
        tipo_o  <= sel.tipo;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a slot-arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = GUARD + DWELL;

  logic       clk = 1'b0;
  logic       rst, clr, key_valid, key_ready, key_tipo, tipo_o, ovf;
  logic [3:0] key_tecla, tecla_o, an;
  logic [1:0] digit_idx;

  int tests = 0;
  int fails = 0;

  display_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_tecla (key_tecla),
    .key_tipo  (key_tipo),
    .tecla_o   (tecla_o),
    .tipo_o    (tipo_o),
    .an        (an),
    .digit_idx (digit_idx),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference state: cycles since reset, key buffer, sticky overflow, slot snapshot.
  int         t;
  bit         mv [NDIG];
  bit         mt [NDIG];
  bit [3:0]   mk [NDIG];
  bit         m_ovf;
  bit [4:0]   snap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit [4:0] disp(int d);
    if (!mv[d]) return {1'b0, 4'hF};
`ifdef LZ_SUPPRESS_EN
    if (d != 0 && mt[d] && mk[d] == 4'h0) begin
      bit lead = 1'b1;
      for (int j = d + 1; j < NDIG; j++)
        if (mv[j] && !(mt[j] && mk[j] == 4'h0)) lead = 1'b0;
      if (lead) return {1'b0, 4'hF};
    end
`endif
    return {mt[d], mk[d]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NDIG; i++) begin
      mv[i] = 1'b0; mt[i] = 1'b0; mk[i] = 4'h0;
    end
    m_ovf = 1'b0;
  endtask

  initial begin
    int  digit, pos;
    bit  show, did_mid_rst;
    logic [3:0] exp_an;

    rst = 1'b1; clr = 1'b0; key_valid = 1'b0; key_tecla = 4'h0; key_tipo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0; model_clear(); snap = {1'b0, 4'hF}; did_mid_rst = 1'b0;
    @(negedge clk);
    chk("rst_tecla", tecla_o, 4'hF);
    chk("rst_tipo", tipo_o, 1'b0);
    @(posedge clk); #1;
    t = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      digit = (t / SLOT) % NDIG;
      pos   = t % SLOT;
      show  = (pos >= GUARD);

      rst = 1'b0; clr = 1'b0; key_valid = 1'b0;
      key_tecla = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      key_tipo  = 1'($urandom_range(0, 1));
      case (cyc)
        40:  begin key_valid = 1'b1; key_tipo = 1'b1; key_tecla = 4'h3; end
        41:  begin key_valid = 1'b1; key_tipo = 1'b0; key_tecla = 4'h0; end
        100, 101, 102, 103, 104: begin
          key_valid = 1'b1; key_tipo = 1'b1; key_tecla = 4'(cyc - 99);
        end
        160: clr = 1'b1;
        200: begin key_valid = 1'b1; clr = 1'b1; end
        default: if (cyc >= 260) begin
          rst       = ($urandom_range(0, 399) == 0);
          clr       = ($urandom_range(0, 79) == 0);
          key_valid = ($urandom_range(0, 15) < 3);
          if (!did_mid_rst && cyc > 500 && digit == 2 && pos == GUARD + 1) begin
            rst = 1'b1;
            did_mid_rst = 1'b1;
          end
        end
      endcase

      @(negedge clk);
      exp_an = show ? ~(4'b0001 << digit) : 4'hF;
      chk("key_ready", key_ready, !clr && !rst);
      chk("an", an, exp_an);
      chk("digit_idx", digit_idx, digit);
      chk("ovf", ovf, m_ovf);
      if (pos != 0) begin
        chk("tecla_o", tecla_o, snap[3:0]);
        chk("tipo_o", tipo_o, snap[4]);
      end

      if (rst) begin
        t = 0;
        model_clear();
        snap = {1'b0, 4'hF};
      end else begin
        if (pos == 0) snap = disp(digit);
        if (clr) begin
          model_clear();
        end else if (key_valid) begin
          if (mv[NDIG-1]) m_ovf = 1'b1;
          for (int i = NDIG - 1; i > 0; i--) begin
            mv[i] = mv[i-1]; mt[i] = mt[i-1]; mk[i] = mk[i-1];
          end
          mv[0] = 1'b1; mt[0] = key_tipo; mk[0] = key_tecla;
        end
        t++;
      end

      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
